// File: rtl/midi_rx_parser.sv
// MIDI 31250-baud 8N1 receiver with channel-voice message assembly and running status.
// Optional MIDI_CHANNEL_FILTER_EN: report only messages on channel CHANNEL.
module midi_rx_parser #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 31250,
  parameter int CHANNEL   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       msg_valid
);
  localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
  localparam int CW      = $clog2(BIT_CNT);
  localparam logic [CW-1:0] HALF_LD = CW'(BIT_CNT / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(BIT_CNT - 1);
`ifdef MIDI_CHANNEL_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic       s1, s2, s_prev, armed, fall;
  logic [1:0] sync_vld;

  // armed only after a genuinely sampled high, so a line low at reset release
  // cannot masquerade as a falling edge against the reset value of the flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      s_prev   <= 1'b1;
      sync_vld <= '0;
      armed    <= 1'b0;
    end else begin
      s1       <= rx_serial;
      s2       <= s1;
      s_prev   <= s2;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && s2) armed <= 1'b1;
    end
  end

  assign fall = armed && s_prev && !s2;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shreg, sh_n;
  logic            byte_ok, ferr, expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bit_idx       <= bit_n;
      shreg         <= sh_n;
      rx_byte_valid <= byte_ok;
      frame_err     <= ferr;
      if (byte_ok) rx_byte <= shreg;
    end
  end

  always_comb begin
    expire  = (cnt == '0);
    state_n = state;
    cnt_n   = expire ? cnt : cnt - 1'b1;
    bit_n   = bit_idx;
    sh_n    = shreg;
    byte_ok = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: if (fall) begin
        state_n = START;
        cnt_n   = HALF_LD;
      end
      START: if (expire) begin
        if (!s2) begin
          state_n = DATA;
          cnt_n   = FULL_LD;
          bit_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: if (expire) begin
        sh_n  = {s2, shreg[7:1]};
        cnt_n = FULL_LD;
        if (bit_idx == 3'd7) state_n = STOP;
        else                 bit_n   = bit_idx + 3'd1;
      end
      STOP: if (expire) begin
        if (s2) begin
          byte_ok = 1'b1;
          state_n = IDLE;
        end else begin
          ferr    = 1'b1;
          state_n = WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (s2) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Message assembly; run_st[7] doubles as the "running status valid" flag
  logic [7:0] run_st;
  logic       have_d1, one_byte, done, chan_ok;
  logic [6:0] d1_q, d1_n, d2_n;

  assign one_byte = (run_st[7:5] == 3'b110);
  assign chan_ok  = !FILTER || (run_st[3:0] == 4'(CHANNEL));
  assign d1_n     = have_d1 ? d1_q : rx_byte[6:0];

  always_comb begin
    done = 1'b0;
    d2_n = rx_byte[6:0];
    if (rx_byte_valid && !rx_byte[7] && run_st[7]) begin
      if (have_d1) begin
        done = 1'b1;
      end else if (one_byte) begin
        done = 1'b1;
        d2_n = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_st     <= '0;
      have_d1    <= 1'b0;
      d1_q       <= '0;
      msg_status <= '0;
      msg_data1  <= '0;
      msg_data2  <= '0;
      msg_valid  <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      if (rx_byte_valid) begin
        if (rx_byte[7]) begin
          if (rx_byte[7:4] != 4'hF) begin
            run_st  <= rx_byte;
            have_d1 <= 1'b0;
          end else if (!rx_byte[3]) begin
            run_st  <= '0;
            have_d1 <= 1'b0;
          end
        end else if (run_st[7]) begin
          if (done) begin
            have_d1 <= 1'b0;
          end else begin
            have_d1 <= 1'b1;
            d1_q    <= rx_byte[6:0];
          end
        end
      end
      if (done && chan_ok) begin
        msg_status <= run_st;
        msg_data1  <= d1_n;
        msg_data2  <= d2_n;
        msg_valid  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_midi_rx_parser.sv
// Scoreboard bench for midi_rx_parser at 16 clocks per bit; expected bytes and
// messages are queued by the stimulus and popped by an independent monitor.
module tb_midi_rx_parser;
  localparam int BIT = 16;

  logic       clk, rst, rx_serial;
  logic [7:0] rx_byte, msg_status;
  logic [6:0] msg_data1, msg_data2;
  logic       rx_byte_valid, frame_err, msg_valid;

  midi_rx_parser #(.CLK_FREQ(BIT * 31250), .BAUD_RATE(31250), .CHANNEL(2)) dut (
    .clk(clk), .rst(rst), .rx_serial(rx_serial),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .frame_err(frame_err),
    .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
    .msg_valid(msg_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int ferr_cnt = 0, ferr_exp = 0;
  logic [7:0]  byte_q[$];
  logic [21:0] msg_q[$];
  logic        prev_rbv = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_rbv = 1'b0;
    end else begin
      if (frame_err) ferr_cnt++;
      if (rx_byte_valid) begin
        if (byte_q.size() == 0) chk("unexpected_rx_byte_valid", {24'h0, rx_byte}, 32'hFFFF_FFFF);
        else chk("rx_byte", {24'h0, rx_byte}, {24'h0, byte_q.pop_front()});
      end
      if (msg_valid) begin
        chk("msg_latency", {31'h0, prev_rbv}, 32'h1);
        if (msg_q.size() == 0) begin
          chk("unexpected_msg_valid", {24'h0, msg_status}, 32'hFFFF_FFFF);
        end else begin
          logic [21:0] m;
          m = msg_q.pop_front();
          chk("msg_status", {24'h0, msg_status}, {24'h0, m[21:14]});
          chk("msg_data1", {25'h0, msg_data1}, {25'h0, m[13:7]});
          chk("msg_data2", {25'h0, msg_data2}, {25'h0, m[6:0]});
        end
      end
      prev_rbv = rx_byte_valid;
    end
  end

  // Called at a negedge; leaves the line at the stop level
  task automatic send(input logic [7:0] b, input logic stop_hi = 1'b1);
    if (stop_hi) byte_q.push_back(b);
    rx_serial = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_serial = stop_hi;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic expect_msg(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2);
    msg_q.push_back({st, d1, d2});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_byte"}, {24'h0, rx_byte}, 32'h0);
    chk({tag, "_rx_byte_valid"}, {31'h0, rx_byte_valid}, 32'h0);
    chk({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
    chk({tag, "_msg_status"}, {24'h0, msg_status}, 32'h0);
    chk({tag, "_msg_data"}, {18'h0, msg_data1, msg_data2}, 32'h0);
    chk({tag, "_msg_valid"}, {31'h0, msg_valid}, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Note On, then running status
    expect_msg(8'h90, 7'h3C, 7'h64);
    send(8'h90); send(8'h3C); send(8'h64);
    expect_msg(8'h90, 7'h40, 7'h00);
    send(8'h40); send(8'h00);
    // Realtime byte inside a controller change
    expect_msg(8'hB1, 7'h07, 7'h7F);
    send(8'hB1); send(8'h07); send(8'hF8); send(8'h7F);
    // Program change: single data byte
    expect_msg(8'hC2, 7'h05, 7'h00);
    send(8'hC2); send(8'h05);
    // SysEx clears running status; trailing data ignored
    send(8'hF0); send(8'h12); send(8'hF7); send(8'h22);
    repeat (3 * BIT) @(negedge clk);

    // Short glitch on idle line
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
    repeat (3 * BIT) @(negedge clk);

    // Framing error followed by a held-low line
    ferr_exp++;
    send(8'h55, 1'b0);
    repeat (20 * BIT) @(negedge clk);
    rx_serial = 1'b1;
    repeat (3 * BIT) @(negedge clk);

    // Reset in bit 4 of 0x3C after 0x90
    send(8'h90);
    rx_serial = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = 8'h3C >> i;
      repeat (BIT) @(negedge clk);
    end
    rx_serial = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midbyte_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    send(8'h3C); send(8'h64);
    repeat (2 * BIT) @(negedge clk);

    // Line low at reset release: nothing until it rises and falls again
    rx_serial = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    rx_serial = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send(8'h45);
    repeat (2 * BIT) @(negedge clk);

    // Channel 1 then channel 2 Note On
`ifndef MIDI_CHANNEL_FILTER_EN
    expect_msg(8'h91, 7'h3C, 7'h64);
`endif
    expect_msg(8'h92, 7'h3C, 7'h64);
    send(8'h91); send(8'h3C); send(8'h64);
    send(8'h92); send(8'h3C); send(8'h64);
    repeat (4 * BIT) @(negedge clk);

    chk("bytes_outstanding", byte_q.size(), 32'h0);
    chk("msgs_outstanding", msg_q.size(), 32'h0);
    chk("frame_err_count", ferr_cnt, ferr_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/midi_rx_parser.md
# midi_rx_parser

Serial MIDI input block: it receives the 31250-baud 8N1 MIDI stream, recovers bytes, and assembles complete channel-voice messages, honouring running status. It is the receiving end of the theremin's MIDI transmit path. It is used both as an external MIDI input to the SoC and as a loopback monitor on the `tx` line in self-test builds. It feeds decoded note and controller messages to downstream synthesis logic.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz.
- `BAUD_RATE`, 31250, serial bit rate.
- `CHANNEL`, 0, MIDI channel (0-15) accepted when the channel filter is compiled in.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_serial`  in  1  MIDI serial input; idle high; asynchronous to `clk`.
- `rx_byte`  out  8  last correctly framed byte.
- `rx_byte_valid`  out  1  one-cycle pulse when `rx_byte` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `msg_status`  out  8  status byte of the last complete message.
- `msg_data1`  out  7  first data byte (note or controller number).
- `msg_data2`  out  7  second data byte (velocity or value); 0 for one-data-byte messages.
- `msg_valid`  out  1  one-cycle pulse when the `msg_*` outputs update.

## Operation
- Reset values: all outputs 0. Running status is cleared. The receiver is in IDLE. The synchroniser flops are 1.
- `rx_serial` passes through a 2-flop synchroniser. All logic uses the synchronised copy.
- Bit period `BIT_CNT = CLK_FREQ/BAUD_RATE` (1600 at the defaults). The counter width is `$clog2(BIT_CNT)`.
- Receiver FSM:
  - IDLE: a 1→0 transition on the synchronised line loads `BIT_CNT/2-1` and moves to START.
  - START: at counter expiry, resample. If the line is low, go to DATA. If it is high, treat it as a glitch and return to IDLE with no output.
  - DATA: sample every `BIT_CNT` cycles. Shift 8 bits, LSB first.
  - STOP: sample once. If high, pulse `rx_byte_valid` and go to IDLE. If low, pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: wait until the line is high, then go to IDLE. This prevents a break condition from retriggering reception.
- Parser. It acts only on `rx_byte_valid`. `frame_err` does not change parser state.
  - Bytes 0x80-0xEF: store as running status and clear the data-byte count.
  - Bytes 0xF0-0xF7 (system common / SysEx): clear running status. Following data bytes are ignored until the next channel status byte.
  - Bytes 0xF8-0xFF (realtime): ignored completely. Running status and any partial message are preserved.
  - Data bytes 0x00-0x7F with no running status: discarded.
  - Data bytes with running status set: stored in data1 or data2 by count.
    - High nibble 0xC or 0xD: complete after 1 data byte; `msg_data2` = 0.
    - High nibble 0x8, 0x9, 0xA, 0xB or 0xE: complete after 2 data bytes.
  - On completion: register `msg_*` and pulse `msg_valid`. Reset the data count and keep the running status, so the next data byte starts a new message.
- Note On with velocity 0 is reported unchanged (status 0x9n, `msg_data2` = 0). Conversion to Note Off is downstream's job.

## Timing
- `rx_byte_valid` is asserted exactly 1 cycle after the stop-bit sample cycle.
- The stop-bit sample occurs `BIT_CNT/2 + 9*BIT_CNT` cycles after the synchronised falling edge, ±1.
- `msg_valid` is asserted exactly 1 cycle after the `rx_byte_valid` of the completing data byte.
- `msg_*` outputs hold their values until the next `msg_valid`. `rx_byte` holds until the next `rx_byte_valid`.
- Back-to-back bytes (stop bit immediately followed by a start bit) are received without loss. IDLE is re-entered before the next falling edge.
- Reset asserted mid-byte or mid-message: immediate return to reset values. Any partial byte and message are lost.
- A line held low at reset release produces no reception until it goes high and then falls again.

## Configuration
- `MIDI_CHANNEL_FILTER_EN`:
  - Defined: a completed message whose low nibble ≠ `CHANNEL` does not pulse `msg_valid` and leaves `msg_*` unchanged. Parser state still advances normally.
  - Undefined: all channels are reported and `CHANNEL` is unused.
  - `rx_byte_valid` is unaffected in both cases.

## Test plan
- Send bytes 0x90, 0x3C, 0x64 at 1600 clk/bit → `msg_valid` once, with `msg_status` 0x90, `msg_data1` 0x3C, `msg_data2` 0x64, 1 cycle after the third `rx_byte_valid`.
- Running status: send 0x90 0x3C 0x64 0x40 0x00 → two `msg_valid` pulses. The second has `msg_data1` 0x40, `msg_data2` 0x00, `msg_status` 0x90.
- Realtime interleave: send 0xB1 0x07 0xF8 0x7F → one `msg_valid` with 0xB1 / 0x07 / 0x7F. A program change 0xC2 0x05 → `msg_valid` with `msg_data2` = 0.
- Errors:
  - 400-cycle low glitch on an idle line → no output.
  - Byte 0x55 with the stop bit forced low → `frame_err` pulse, no `rx_byte_valid`, line then held low 5000 cycles → no further pulses.
- Assert `rst` low during bit 4 of 0x3C, after 0x90 was already received, then send 0x3C 0x64 → no `msg_valid`, because running status was cleared. All outputs read 0 during reset.
- With `MIDI_CHANNEL_FILTER_EN`, `CHANNEL`=2: send 0x91 0x3C 0x64 then 0x92 0x3C 0x64 → exactly one `msg_valid` (status 0x92) and six `rx_byte_valid` pulses.
